// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of the SDRAM controller, with an
// in-order return-ID FIFO for pipelined reads. Optional macro SDRAM_ARB_ERR_EN adds err_unexp_rdv.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid
`ifdef SDRAM_ARB_ERR_EN
    ,
    output logic                err_unexp_rdv
`endif
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(MAX_PENDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q;
    logic             grant_q;
    logic             last_grant_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             id_mem_q [MAX_PENDING];

    logic              req0, req1, busy, full, empty;
    logic              sel_read, sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BE_W-1:0]   sel_be;
    logic              accept, push, pop, drop, head_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign busy = (state_q == BUSY);

    // Granted master's command, presented to the slave only while BUSY
    assign sel_read  = grant_q ? m1_read       : m0_read;
    assign sel_write = grant_q ? m1_write      : m0_write;
    assign sel_addr  = grant_q ? m1_address    : m0_address;
    assign sel_wdata = grant_q ? m1_writedata  : m0_writedata;
    assign sel_be    = grant_q ? m1_byteenable : m0_byteenable;

    assign full  = (count_q == CNT_W'(MAX_PENDING));
    assign empty = (count_q == '0);

    assign s_read       = busy & sel_read & ~full;
    assign s_write      = busy & sel_write;
    assign s_address    = busy ? sel_addr  : '0;
    assign s_writedata  = busy ? sel_wdata : '0;
    assign s_byteenable = busy ? sel_be    : '0;

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign push   = accept & s_read;
    assign drop   = busy & ~sel_read & ~sel_write;

    assign m0_waitrequest = ~(accept & ~grant_q);
    assign m1_waitrequest = ~(accept & grant_q);

    // Returns are routed by the oldest outstanding read ID
    assign head_id          = id_mem_q[rd_ptr_q];
    assign pop              = s_readdatavalid & ~empty;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop & head_id;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        grant_q <= (req0 & req1) ? ~last_grant_q : req1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        last_grant_q <= grant_q;
                        state_q      <= IDLE;
                    end else if (drop) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) id_mem_q[wr_ptr_q] <= grant_q;
    end

`ifdef SDRAM_ARB_ERR_EN
    logic err_q;

    // Sticky flag: stray return data or a granted master withdrawing its request
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            err_q <= 1'b0;
        end else if ((s_readdatavalid & empty) | drop) begin
            err_q <= 1'b1;
        end
    end

    assign err_unexp_rdv = err_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_sdram_port_arbiter;

    localparam int unsigned MAXP = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [21:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [21:0] s_address;
    logic        s_read, s_write;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
`ifdef SDRAM_ARB_ERR_EN
    logic        err_unexp_rdv;
`endif

    sdram_port_arbiter dut (
`ifdef SDRAM_ARB_ERR_EN
        .err_unexp_rdv    (err_unexp_rdv),
`endif
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid)
    );

    always #5 clk_clk = ~clk_clk;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: current owner (-1 = nobody), contention winner, outstanding read owners
    int          owner = -1;
    int          prio  = 0;
    int          pend[$];
    bit          exp_err = 1'b0;
    logic [15:0] mq0[$], mq1[$], sq[$];
    bit          rand_phase = 1'b0;

    logic        o_sread, o_swrite, o_w0, o_w1, o_v0, o_v1, o_err;
    logic [21:0] o_addr;
    logic [15:0] o_wd, o_rd;
    logic [1:0]  o_be;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] mem_f(input logic [21:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {10'd0, a[21:16]};
    endfunction

    // Compare DUT against the model for the current cycle, then advance the model
    task automatic settle();
        logic [1:0]  ew, ev;
        logic [41:0] ecmd;
        logic        rd, wr;
        logic [21:0] a;
        bit          acc, esr;
        int          nxt;
        #1;
        o_sread = s_read;  o_swrite = s_write; o_addr = s_address; o_wd = s_writedata;
        o_be = s_byteenable; o_w0 = m0_waitrequest; o_w1 = m1_waitrequest;
        o_v0 = m0_readdatavalid; o_v1 = m1_readdatavalid; o_rd = m0_readdata; o_err = 1'b0;
`ifdef SDRAM_ARB_ERR_EN
        o_err = err_unexp_rdv;
`endif
        if (reset_reset) begin
            owner = -1; prio = 0; exp_err = 1'b0;
            pend.delete(); mq0.delete(); mq1.delete(); sq.delete();
            return;
        end
        ecmd = '0; ew = 2'b11; acc = 1'b0; esr = 1'b0; rd = 1'b0; wr = 1'b0; a = '0;
        if (owner >= 0) begin
            rd  = (owner == 1) ? m1_read : m0_read;
            wr  = (owner == 1) ? m1_write : m0_write;
            a   = (owner == 1) ? m1_address : m0_address;
            esr = rd && (pend.size() < MAXP);
            acc = (esr || wr) && !s_waitrequest;
            ecmd = {esr, wr, a, (owner == 1) ? m1_writedata : m0_writedata,
                    (owner == 1) ? m1_byteenable : m0_byteenable};
            if (owner == 1) ew[1] = !acc; else ew[0] = !acc;
        end
        check("slave cmd", {s_read, s_write, s_address, s_writedata, s_byteenable}, ecmd);
        check("waitrequest", {m1_waitrequest, m0_waitrequest}, ew);
`ifdef SDRAM_ARB_ERR_EN
        check("err_unexp_rdv", err_unexp_rdv, exp_err);
`endif
        ev = 2'b00;
        if (s_readdatavalid) begin
            if (pend.size() > 0) begin
                if (pend[0] == 1) ev[1] = 1'b1; else ev[0] = 1'b1;
                void'(pend.pop_front());
            end else begin
                exp_err = 1'b1;
            end
            check("readdata bcast", {m1_readdata, m0_readdata}, {s_readdata, s_readdata});
        end
        check("readdatavalid", {m1_readdatavalid, m0_readdatavalid}, ev);
        if (rand_phase && m0_readdatavalid) begin
            if (mq0.size() > 0) check("m0 read data", m0_readdata, mq0.pop_front());
            else check("m0 unexpected return", 1, 0);
        end
        if (rand_phase && m1_readdatavalid) begin
            if (mq1.size() > 0) check("m1 read data", m1_readdata, mq1.pop_front());
            else check("m1 unexpected return", 1, 0);
        end
        nxt = owner;
        if (owner < 0) begin
            if ((m0_read || m0_write) && (m1_read || m1_write)) nxt = prio;
            else if (m0_read || m0_write) nxt = 0;
            else if (m1_read || m1_write) nxt = 1;
        end else if (acc) begin
            if (esr) begin
                pend.push_back(owner);
                if (rand_phase) begin
                    if (owner == 1) mq1.push_back(mem_f(a)); else mq0.push_back(mem_f(a));
                end
            end
            prio = 1 - owner;
            nxt  = -1;
        end else if (!rd && !wr) begin
            nxt     = -1;
            exp_err = 1'b1;
        end
        owner = nxt;
    endtask

    task automatic adv();
        @(posedge clk_clk);
        @(negedge clk_clk);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
        m0_byteenable = 2'b11; m1_byteenable = 2'b11;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        cyc();
        reset_reset = 1'b0;
    endtask

    logic [15:0] exp_wd [8] = '{16'h0, 16'h1111, 16'h0, 16'h2222, 16'h0, 16'h1111, 16'h0, 16'h2222};
    logic [1:0]  exp_w  [8] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};

    bit          mb [2];
    bit          mrd[2];
    logic [21:0] ma [2];
    logic [15:0] md [2];
    logic [1:0]  mbe[2];

    initial begin
        int n;
        idle_inputs();
        reset_reset = 1'b1;
        @(negedge clk_clk);
        do_reset();

        // Reset state
        cyc();
        check("reset waitreq", {o_w1, o_w0}, 2'b11);
        check("reset cmd", {o_sread, o_swrite, o_addr, o_wd, o_be}, '0);
        check("reset rdv", {o_v1, o_v0}, 2'b00);

        // Single read from m0
        m0_read = 1; m0_address = 22'h000123;
        cyc();
        check("single arb cycle s_read", o_sread, 0);
        cyc();
        check("single s_read/addr", {o_sread, o_addr}, {1'b1, 22'h000123});
        check("single waitreq", {o_w1, o_w0}, 2'b10);
        m0_read = 0;
        cyc();
        cyc();
        s_readdatavalid = 1; s_readdata = 16'hBEEF;
        cyc();
        check("single return", {o_v1, o_v0, o_rd}, {2'b01, 16'hBEEF});
        s_readdatavalid = 0;

        // Contention: both masters write continuously
        do_reset();
        m0_write = 1; m0_address = 22'h10; m0_writedata = 16'h1111;
        m1_write = 1; m1_address = 22'h20; m1_writedata = 16'h2222;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("contention cmd", {o_swrite, o_wd}, {1'(i % 2), exp_wd[i]});
            check("contention waitreq", {o_w1, o_w0}, exp_w[i]);
        end
        idle_inputs();

        // Backpressure on an m1 write
        do_reset();
        s_waitrequest = 1;
        m1_write = 1; m1_address = 22'h2AAAAA; m1_writedata = 16'hCAFE; m1_byteenable = 2'b10;
        cyc();
        m0_write = 1; m0_address = 22'h33; m0_writedata = 16'h3333;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) s_waitrequest = 0;
            cyc();
            check("bp cmd stable", {o_swrite, o_addr, o_wd, o_be}, {1'b1, 22'h2AAAAA, 16'hCAFE, 2'b10});
            check("bp waitreq", {o_w1, o_w0}, (i == 5) ? 2'b01 : 2'b11);
        end
        m1_write = 0;
        cyc();
        cyc();
        check("bp m0 after", {o_swrite, o_wd, o_w0}, {1'b1, 16'h3333, 1'b0});
        idle_inputs();

        // FIFO full: four m0 reads outstanding, then an m1 read stalls until a pop
        do_reset();
        m0_read = 1; m0_address = 22'h100; n = 0;
        for (int i = 0; i < 12 && n < 4; i++) begin
            cyc();
            if (!o_w0) begin
                n++;
                m0_address = m0_address + 22'd1;
                if (n == 4) m0_read = 0;
            end
        end
        check("fifo fill accepts", n, 4);
        m0_read = 0;
        m1_read = 1; m1_address = 22'h55;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("full stall", {o_sread, o_w1}, 2'b01);
        end
        s_readdatavalid = 1; s_readdata = 16'h0A01;
        cyc();
        check("full first pop", {o_v1, o_v0, o_sread}, 3'b010);
        s_readdatavalid = 0;
        cyc();
        check("full m1 accept", {o_sread, o_w1, o_addr}, {2'b10, 22'h55});
        m1_read = 0;
        for (int k = 0; k < 4; k++) begin
            s_readdatavalid = 1; s_readdata = 16'h0A02 + 16'(k);
            cyc();
            check("full return route", {o_v1, o_v0}, (k == 3) ? 2'b10 : 2'b01);
        end
        s_readdatavalid = 0;
        cyc();

        // Reset with two reads in flight
        do_reset();
        m0_read = 1; m0_address = 22'h200; n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            cyc();
            if (!o_w0) begin
                n++;
                m0_address = m0_address + 22'd1;
                if (n == 2) m0_read = 0;
            end
        end
        check("pre-reset accepts", n, 2);
        m0_read = 0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            s_readdatavalid = 1; s_readdata = 16'h7777;
            cyc();
            check("post-reset rdv", {o_v1, o_v0}, 2'b00);
            check("post-reset outputs", {o_w1, o_w0, o_sread, o_swrite, o_addr}, {2'b11, 2'b00, 22'h0});
            s_readdatavalid = 0;
            cyc();
        end
`ifdef SDRAM_ARB_ERR_EN
        check("post-reset err", o_err, 1);
`endif

        // Randomized traffic
        idle_inputs();
        do_reset();
        rand_phase = 1;
        for (int m = 0; m < 2; m++) mb[m] = 0;
        for (int t = 0; t < 4300; t++) begin
            bit draining;
            draining = (t >= 4000);
            for (int m = 0; m < 2; m++) begin
                if (mb[m] && !draining && $urandom_range(0, 63) == 0) begin
                    mb[m] = 0;
                end else if (!mb[m] && !draining && $urandom_range(0, 99) < 40) begin
                    mb[m]  = 1;
                    mrd[m] = 1'($urandom_range(0, 1));
                    ma[m]  = 22'($urandom);
                    md[m]  = 16'($urandom);
                    mbe[m] = 2'($urandom_range(1, 3));
                end
            end
            m0_read = mb[0] & mrd[0]; m0_write = mb[0] & ~mrd[0];
            m1_read = mb[1] & mrd[1]; m1_write = mb[1] & ~mrd[1];
            m0_address = ma[0]; m0_writedata = md[0]; m0_byteenable = mbe[0];
            m1_address = ma[1]; m1_writedata = md[1]; m1_byteenable = mbe[1];
            s_waitrequest = ($urandom_range(0, 3) == 0);
            if (sq.size() > 0 && $urandom_range(0, 1) == 1) begin
                s_readdatavalid = 1; s_readdata = sq.pop_front();
            end else if (sq.size() == 0 && !draining && $urandom_range(0, 63) == 0) begin
                s_readdatavalid = 1; s_readdata = 16'($urandom);
            end else begin
                s_readdatavalid = 0;
            end
            settle();
            if (s_read && !s_waitrequest) sq.push_back(mem_f(s_address));
            if (mb[0] && !o_w0) mb[0] = 0;
            if (mb[1] && !o_w1) mb[1] = 0;
            adv();
        end
        check("drain complete", {32'(sq.size() + mq0.size() + mq1.size() + pend.size()),
                                 30'd0, mb[1], mb[0]}, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
